// File: rtl/permutation_pipeline_checker_if.sv
// Bundle of the pipeline-facing signals: top transfer, bot stream and result return.
interface permutation_pipeline_checker_if #(
    parameter int unsigned BOT_WIDTH   = 128,
    parameter int unsigned SUM_WIDTH   = 48,
    parameter int unsigned COUNT_WIDTH = 13
);
    logic [BOT_WIDTH-1:0]   top;
    logic                   transmitTop;
    logic                   doneTransmitting;
    logic [BOT_WIDTH-1:0]   botIn;
    logic                   writeBotIn;
    logic                   almostFull;
    logic                   slowDown;
    logic                   resultValid;
    logic [SUM_WIDTH-1:0]   pcoeffSum;
    logic [COUNT_WIDTH-1:0] pcoeffCount;

    // Checker side: drives the pipeline inputs, observes its results.
    modport master (
        output top, transmitTop, botIn, writeBotIn, slowDown,
        input  doneTransmitting, almostFull, resultValid, pcoeffSum, pcoeffCount
    );

    // Pipeline side.
    modport slave (
        input  top, transmitTop, botIn, writeBotIn, slowDown,
        output doneTransmitting, almostFull, resultValid, pcoeffSum, pcoeffCount
    );
endinterface

// File: rtl/permutation_pipeline_checker.sv
// Self-checking traffic driver for the permutation pipeline: loads the top from ROM entry 0,
// streams bots from ROM, and checks each returned result against the expected ROM fields.
module permutation_pipeline_checker #(
    parameter int unsigned BOT_WIDTH   = 128,
    parameter int unsigned SUM_WIDTH   = 48,
    parameter int unsigned COUNT_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned FIRST_INDEX = 2,
    parameter int unsigned SLOW_PERIOD = 64,
    parameter int unsigned ERR_WIDTH   = 16,
    localparam int unsigned ROM_WIDTH  = 1 + BOT_WIDTH + 16 + SUM_WIDTH
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  numVectors,
    input  logic                   haltOnError,
    input  logic [1:0]             slowMode,
    output logic [ADDR_WIDTH-1:0]  romAddrIn,
    output logic [ADDR_WIDTH-1:0]  romAddrOut,
    input  logic [ROM_WIDTH-1:0]   romDataIn,
    input  logic [ROM_WIDTH-1:0]   romDataOut,
    permutation_pipeline_checker_if.master pipe,
    output logic [2:0]             state,
    output logic [ERR_WIDTH-1:0]   errorCount,
    output logic [ERR_WIDTH-1:0]   passCount,
    output logic [ERR_WIDTH-1:0]   topResultCount,
    output logic                   firstErrValid,
    output logic [ADDR_WIDTH-1:0]  firstErrIndex,
    output logic [SUM_WIDTH-1:0]   firstErrSum,
    output logic [COUNT_WIDTH-1:0] firstErrCount,
    output logic                   overrun
);
    localparam int unsigned SLOW_W = $clog2(SLOW_PERIOD);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoadTop = 3'd1,
        StSendTop = 3'd2,
        StWaitTop = 3'd3,
        StRun     = 3'd4,
        StDone    = 3'd5,
        StHalted  = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  num_q, num_d, in_idx_q, in_idx_d, out_idx_q, out_idx_d;
    logic                   halt_q, halt_d;
    logic [BOT_WIDTH-1:0]   top_q, top_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d, pass_q, pass_d, topres_q, topres_d;
    logic                   ferr_valid_q, ferr_valid_d, overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0]  ferr_idx_q, ferr_idx_d;
    logic [SUM_WIDTH-1:0]   ferr_sum_q, ferr_sum_d;
    logic [COUNT_WIDTH-1:0] ferr_cnt_q, ferr_cnt_d;
    logic [SLOW_W-1:0]      slow_cnt_q, slow_cnt_d;
    logic                   slow_q, slow_d;

    logic                   write_bot, checking, match, accept_start;
    logic [SUM_WIDTH-1:0]   exp_sum;
    logic [COUNT_WIDTH-1:0] exp_cnt;
    logic                   unused_rom_bits;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Datapath decode and the combinational ROM address lookahead on both sides.
    always_comb begin
        exp_sum      = romDataOut[SUM_WIDTH-1:0];
        exp_cnt      = romDataOut[SUM_WIDTH +: COUNT_WIDTH];
        // HALTED keeps checking in-flight results, so it must keep the output-side lookahead too.
        checking     = pipe.resultValid && (state_q == StRun || state_q == StHalted);
        match        = (exp_sum == pipe.pcoeffSum) && (exp_cnt == pipe.pcoeffCount);
        write_bot    = (state_q == StRun) && (in_idx_q < num_q) && !pipe.almostFull;
        accept_start = start && (state_q == StIdle || state_q == StDone || state_q == StHalted);
        romAddrIn    = (state_q == StLoadTop) ? '0 : in_idx_q + ADDR_WIDTH'(write_bot);
        romAddrOut   = out_idx_q + ADDR_WIDTH'(checking);
        unused_rom_bits = ^{romDataIn[ROM_WIDTH-1], romDataIn[SUM_WIDTH+15:0],
                            romDataOut[ROM_WIDTH-2:SUM_WIDTH+COUNT_WIDTH]};
    end

    // Next-state: FSM transitions, index advance, result scoring and error capture.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        halt_d       = halt_q;
        in_idx_d     = in_idx_q;
        out_idx_d    = out_idx_q;
        top_d        = top_q;
        err_d        = err_q;
        pass_d       = pass_q;
        topres_d     = topres_q;
        ferr_valid_d = ferr_valid_q;
        ferr_idx_d   = ferr_idx_q;
        ferr_sum_d   = ferr_sum_q;
        ferr_cnt_d   = ferr_cnt_q;
        overrun_d    = overrun_q;

        if (write_bot) in_idx_d = in_idx_q + ADDR_WIDTH'(1);

        if (checking) begin
            out_idx_d = out_idx_q + ADDR_WIDTH'(1);
            if (match) begin
                pass_d = sat_inc(pass_q);
            end else begin
                err_d = sat_inc(err_q);
                if (!ferr_valid_q) begin
                    ferr_valid_d = 1'b1;
                    ferr_idx_d   = out_idx_q;
                    ferr_sum_d   = pipe.pcoeffSum;
                    ferr_cnt_d   = pipe.pcoeffCount;
                end
            end
            if (romDataOut[ROM_WIDTH-1]) topres_d = sat_inc(topres_q);
        end else if (pipe.resultValid) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone, StHalted: ;
            StLoadTop: state_d = StSendTop;
            StSendTop: begin
                top_d   = romDataIn[SUM_WIDTH+16 +: BOT_WIDTH];
                state_d = StWaitTop;
            end
            StWaitTop: begin
                if (pipe.doneTransmitting) begin
                    state_d = (num_q <= ADDR_WIDTH'(FIRST_INDEX)) ? StDone : StRun;
                end
            end
            StRun: begin
                if (checking && !match && halt_q) state_d = StHalted;
                else if (out_idx_q == num_q)      state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        // A new run discards the previous run's scores and sticky flags.
        if (accept_start) begin
            state_d      = StLoadTop;
            num_d        = numVectors;
            halt_d       = haltOnError;
            in_idx_d     = ADDR_WIDTH'(FIRST_INDEX);
            out_idx_d    = ADDR_WIDTH'(FIRST_INDEX);
            err_d        = '0;
            pass_d       = '0;
            topres_d     = '0;
            ferr_valid_d = 1'b0;
            ferr_idx_d   = '0;
            ferr_sum_d   = '0;
            ferr_cnt_d   = '0;
            overrun_d    = 1'b0;
        end
    end

    // Output throttle: free-running period counter, registered so mode changes land next cycle.
    always_comb begin
        slow_cnt_d = (slow_cnt_q == SLOW_W'(SLOW_PERIOD - 1)) ? '0 : slow_cnt_q + SLOW_W'(1);
        slow_d     = (slowMode == 2'd1) ||
                     ((slowMode == 2'd2) && (slow_cnt_q < SLOW_W'(SLOW_PERIOD / 2)));
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q      <= StIdle;
            num_q        <= '0;
            halt_q       <= 1'b0;
            in_idx_q     <= '0;
            out_idx_q    <= '0;
            top_q        <= '0;
            err_q        <= '0;
            pass_q       <= '0;
            topres_q     <= '0;
            ferr_valid_q <= 1'b0;
            ferr_idx_q   <= '0;
            ferr_sum_q   <= '0;
            ferr_cnt_q   <= '0;
            overrun_q    <= 1'b0;
            slow_cnt_q   <= '0;
            slow_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            halt_q       <= halt_d;
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            top_q        <= top_d;
            err_q        <= err_d;
            pass_q       <= pass_d;
            topres_q     <= topres_d;
            ferr_valid_q <= ferr_valid_d;
            ferr_idx_q   <= ferr_idx_d;
            ferr_sum_q   <= ferr_sum_d;
            ferr_cnt_q   <= ferr_cnt_d;
            overrun_q    <= overrun_d;
            slow_cnt_q   <= slow_cnt_d;
            slow_q       <= slow_d;
        end
    end

    assign pipe.top         = top_q;
    assign pipe.transmitTop = (state_q == StSendTop);
    assign pipe.botIn       = (state_q == StRun) ? romDataIn[SUM_WIDTH+16 +: BOT_WIDTH] : '0;
    assign pipe.writeBotIn  = write_bot;
    assign pipe.slowDown    = slow_q;
    assign state            = state_q;
    assign errorCount       = err_q;
    assign passCount        = pass_q;
    assign topResultCount   = topres_q;
    assign firstErrValid    = ferr_valid_q;
    assign firstErrIndex    = ferr_idx_q;
    assign firstErrSum      = ferr_sum_q;
    assign firstErrCount    = ferr_cnt_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_permutation_pipeline_checker.sv
// Bench for permutation_pipeline_checker: ROM model, ideal pipeline model with optional sum
// corruption, and a scoreboard of the bot sequence the checker is expected to stream.
module tb_permutation_pipeline_checker;
    localparam int BW = 128, SW = 48, CW = 13, AW = 11, RW = 1 + BW + 16 + SW;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SEND = 3'd2, S_WAIT = 3'd3;
    localparam logic [2:0] S_RUN = 3'd4, S_DONE = 3'd5, S_HALT = 3'd6;
    localparam int DLY = 2;                       // model result latency in cycles
    localparam int HALT_FED = (5 - 2 + 1) + DLY;  // bots fed before the entry-5 mismatch halts

    logic clk = 1'b0;
    logic rst, start, haltOnError, inject, corrupt;
    logic [AW-1:0] numVectors, romAddrIn, romAddrOut, firstErrIndex;
    logic [1:0] slowMode;
    logic [RW-1:0] romDataIn, romDataOut;
    logic [RW-1:0] rom [16];
    logic [2:0] st;
    logic [15:0] errorCount, passCount, topResultCount;
    logic firstErrValid, overrun;
    logic [SW-1:0] firstErrSum;
    logic [CW-1:0] firstErrCount;
    logic [BW-1:0] bot_q [$];
    int total = 0, bad = 0, fed = 0;

    permutation_pipeline_checker_if #(.BOT_WIDTH(BW), .SUM_WIDTH(SW), .COUNT_WIDTH(CW)) pif ();

    permutation_pipeline_checker dut (
        .clock(clk), .rst(rst), .start(start), .numVectors(numVectors),
        .haltOnError(haltOnError), .slowMode(slowMode), .romAddrIn(romAddrIn),
        .romAddrOut(romAddrOut), .romDataIn(romDataIn), .romDataOut(romDataOut), .pipe(pif),
        .state(st), .errorCount(errorCount), .passCount(passCount),
        .topResultCount(topResultCount), .firstErrValid(firstErrValid),
        .firstErrIndex(firstErrIndex), .firstErrSum(firstErrSum),
        .firstErrCount(firstErrCount), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle read latency on both ports.
    always @(posedge clk) begin
        romDataIn  <= rom[romAddrIn[3:0]];
        romDataOut <= rom[romAddrOut[3:0]];
    end

    function automatic logic [SW-1:0] f_sum(input logic [BW-1:0] b);
        return b[47:0] + b[95:48];
    endfunction

    function automatic logic [CW-1:0] f_cnt(input logic [BW-1:0] b);
        return CW'($countones(b));
    endfunction

    function automatic logic [BW-1:0] bot_of(input int e);
        logic [RW-1:0] w;
        w = rom[e];
        return w[SW+16 +: BW];
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input string tag);
        int n = 0;
        while (st !== tgt && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, st, tgt);
    endtask

    task automatic push_bots(input int last);
        bot_q.delete();
        for (int e = 2; e < last; e++) bot_q.push_back(bot_of(e));
    endtask

    // Starts a run and walks the top handshake; returns at the first cycle after WAIT_TOP.
    task automatic run_start(input logic [AW-1:0] nv, input logic h, input logic [2:0] end_st);
        @(negedge clk);
        numVectors = nv; haltOnError = h; start = 1'b1; fed = 0;
        @(negedge clk);
        start = 1'b0;
        chk("load_top_state", st, S_LOAD);
        chk("load_top_addr", romAddrIn, 0);
        @(negedge clk);
        chk("send_top_state", st, S_SEND);
        chk("send_top_pulse", pif.transmitTop, 1);
        @(negedge clk);
        chk("top_value", pif.top, bot_of(0));
        chk("transmit_once", pif.transmitTop, 0);
        repeat (2) @(negedge clk);
        chk("wait_top_hold", st, S_WAIT);
        pif.doneTransmitting = 1'b1;
        @(negedge clk);
        pif.doneTransmitting = 1'b0;
        chk("after_wait_top", st, end_st);
    endtask

    // Ideal pipeline: scoreboards each bot, returns its result DLY cycles later.
    initial begin
        logic          dv [DLY+1];
        logic [SW-1:0] ds [DLY+1];
        logic [CW-1:0] dc [DLY+1];
        for (int i = 0; i <= DLY; i++) begin dv[i] = 1'b0; ds[i] = '0; dc[i] = '0; end
        pif.resultValid = 1'b0; pif.pcoeffSum = '0; pif.pcoeffCount = '0;
        forever begin
            @(negedge clk);
            #2;
            for (int i = DLY; i > 0; i--) begin dv[i] = dv[i-1]; ds[i] = ds[i-1]; dc[i] = dc[i-1]; end
            dv[0] = (pif.writeBotIn === 1'b1);
            ds[0] = f_sum(pif.botIn);
            dc[0] = f_cnt(pif.botIn);
            if (dv[0]) begin
                fed++;
                chk("bot_expected", bot_q.size() > 0, 1);
                if (bot_q.size() > 0) chk("bot_seq", pif.botIn, bot_q.pop_front());
                if (corrupt && pif.botIn === bot_of(5)) ds[0] = ds[0] + 1'b1;
            end
            pif.resultValid = dv[DLY] | inject;
            pif.pcoeffSum   = ds[DLY];
            pif.pcoeffCount = dc[DLY];
        end
    end

    initial begin
        int n, n_low, n_high;
        logic [11:0] pat;
        logic prev, found;
        rst = 1'b0; start = 1'b0; haltOnError = 1'b0; numVectors = '0; slowMode = 2'd0;
        inject = 1'b0; corrupt = 1'b0; pif.almostFull = 1'b0; pif.doneTransmitting = 1'b0;
        for (int e = 0; e < 16; e++) begin
            logic [BW-1:0] b;
            b = {$urandom, $urandom, $urandom, $urandom};
            rom[e] = (e < 10) ? {(e == 0 || e == 3 || e == 7), b, 16'(f_cnt(b)), f_sum(b)} : '0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_state", st, S_IDLE);
        chk("rst_counters", {errorCount, passCount, topResultCount}, 0);
        chk("rst_outputs", {pif.writeBotIn, pif.transmitTop, pif.slowDown, overrun, firstErrValid}, 0);
        chk("rst_top", pif.top, 0);
        rst = 1'b1;

        // Ideal run: eight back-to-back bots, all pass.
        push_bots(10);
        run_start(11'd10, 1'b0, S_RUN);
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            n += int'(pif.writeBotIn);
        end
        chk("ideal_consecutive_writes", n, 8);
        @(negedge clk);
        chk("ideal_feed_stops", pif.writeBotIn, 0);
        wait_state(S_DONE, "ideal_done");
        chk("ideal_pass", passCount, 8);
        chk("ideal_err", errorCount, 0);
        chk("ideal_top_results", topResultCount, 2);
        chk("ideal_overrun", overrun, 0);
        chk("ideal_sb_empty", bot_q.size(), 0);

        // numVectors at FIRST_INDEX: no bots, straight to DONE.
        push_bots(2);
        run_start(11'd2, 1'b0, S_DONE);
        repeat (4) @(negedge clk);
        chk("empty_run_fed", fed, 0);
        chk("empty_run_pass", passCount, 0);

        // almostFull during RUN cycles 3..5.
        push_bots(10);
        run_start(11'd10, 1'b0, S_RUN);
        pat = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            pif.almostFull = (k >= 3 && k <= 5);
            #1 pat[k-1] = pif.writeBotIn;
        end
        pif.almostFull = 1'b0;
        chk("af_write_pattern", pat, 12'h7E3);
        wait_state(S_DONE, "af_done");
        chk("af_pass", passCount, 8);
        chk("af_sb_empty", bot_q.size(), 0);

        // Corrupted entry 5 with halt-on-error.
        corrupt = 1'b1;
        push_bots(10);
        run_start(11'd10, 1'b1, S_RUN);
        wait_state(S_HALT, "halt_state");
        repeat (6) @(negedge clk);
        chk("halt_state_held", st, S_HALT);
        chk("halt_err", errorCount, 1);
        chk("halt_pass", passCount, HALT_FED - 1);
        chk("halt_fed", fed, HALT_FED);
        chk("halt_feed_off", pif.writeBotIn, 0);
        chk("halt_ferr_valid", firstErrValid, 1);
        chk("halt_ferr_index", firstErrIndex, 5);
        chk("halt_ferr_sum", firstErrSum, f_sum(bot_of(5)) + 1'b1);
        chk("halt_ferr_count", firstErrCount, f_cnt(bot_of(5)));

        // Same corruption without halting, restarted from HALTED.
        push_bots(10);
        run_start(11'd10, 1'b0, S_RUN);
        wait_state(S_DONE, "nohalt_done");
        chk("nohalt_err", errorCount, 1);
        chk("nohalt_pass", passCount, 7);
        chk("nohalt_ferr_index", firstErrIndex, 5);
        chk("nohalt_top_results", topResultCount, 2);
        corrupt = 1'b0;

        // Periodic slowDown: find a falling edge, then measure a full low and high phase.
        @(negedge clk);
        slowMode = 2'd2;
        prev = pif.slowDown;
        found = 1'b0;
        for (int k = 0; k < 140 && !found; k++) begin
            @(negedge clk);
            if (prev === 1'b1 && pif.slowDown === 1'b0) found = 1'b1;
            prev = pif.slowDown;
        end
        chk("slow_fall_found", found, 1);
        n_low = 0;
        while (pif.slowDown === 1'b0 && n_low < 100) begin n_low++; @(negedge clk); end
        n_high = 0;
        while (pif.slowDown === 1'b1 && n_high < 100) begin n_high++; @(negedge clk); end
        chk("slow_low_len", n_low, 32);
        chk("slow_high_len", n_high, 32);
        slowMode = 2'd1;
        @(negedge clk);
        chk("slow_always", pif.slowDown, 1);
        slowMode = 2'd0;
        @(negedge clk);
        chk("slow_never", pif.slowDown, 0);

        // Reset mid-RUN, stray result in IDLE, then identical restart.
        push_bots(10);
        run_start(11'd10, 1'b0, S_RUN);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_state", st, S_IDLE);
        chk("midrst_counters", {errorCount, passCount, topResultCount}, 0);
        chk("midrst_feed", pif.writeBotIn, 0);
        repeat (4) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (2) @(negedge clk);
        chk("overrun_set", overrun, 1);
        chk("overrun_no_score", passCount, 0);
        push_bots(10);
        run_start(11'd10, 1'b0, S_RUN);
        wait_state(S_DONE, "restart_done");
        chk("restart_pass", passCount, 8);
        chk("restart_err", errorCount, 0);
        chk("restart_top_results", topResultCount, 2);
        chk("restart_overrun_cleared", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
